// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, divide step count.
package mdu_pkg;

   localparam int DIV_STEPS = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_MADD  = 3'd2,
      OP_MSUB  = 3'd3,
      OP_DIV   = 3'd4,
      OP_DIVU  = 3'd5,
      OP_MTHI  = 3'd6,
      OP_MTLO  = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIV   = 2'd1,
      S_FIXUP = 2'd2
   } state_t;

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between Execute and the multiply/divide unit.
interface mdu_if;
   import mdu_pkg::*;

   logic        Start;
   op_t         Op;
   logic [31:0] OperandA;
   logic [31:0] OperandB;
   logic        Busy;
   logic        Done;
   logic [31:0] HiData;
   logic [31:0] LoData;

   modport master (output Start, Op, OperandA, OperandB,
                   input  Busy, Done, HiData, LoData);
   modport slave  (input  Start, Op, OperandA, OperandB,
                   output Busy, Done, HiData, LoData);
endinterface

// File: rtl/mdu_divider.sv
// Unsigned restoring divider, one quotient bit per clock. Only built when MDU_DIV_EN is defined.
module mdu_divider #(
   parameter int DIV_STEPS = mdu_pkg::DIV_STEPS
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);
   logic [5:0]  cnt;
   logic        run;
   logic [31:0] q, r, d;
   logic [32:0] shifted, diff;

   // Partial remainder stays below the divisor, so bit 32 of diff is set only on borrow.
   assign shifted = {r, q[31]};
   assign diff    = shifted - {1'b0, d};

   always_ff @(posedge clk) begin
      if (rst) begin
         run <= 1'b0;
         cnt <= '0;
         q   <= '0;
         r   <= '0;
         d   <= '0;
      end else if (start) begin
         run <= 1'b1;
         cnt <= '0;
         q   <= dividend;
         r   <= '0;
         d   <= divisor;
      end else if (run) begin
         q   <= {q[30:0], ~diff[32]};
         r   <= diff[32] ? shifted[31:0] : diff[31:0];
         cnt <= cnt + 6'd1;
         if (cnt == 6'(DIV_STEPS - 1)) run <= 1'b0;
      end
   end

   // Flags the cycle whose closing edge performs the final step.
   assign done      = run && (cnt == 6'(DIV_STEPS - 1));
   assign quotient  = q;
   assign remainder = r;
endmodule

// File: rtl/mult_div_unit.sv
// HI/LO owner: single-cycle multiply/accumulate, iterative divide when MDU_DIV_EN is defined.
module mult_div_unit (
   input  logic  Clk,
   input  logic  Rst,
   mdu_if.slave  bus
);
   import mdu_pkg::*;

   state_t      state;
   logic [31:0] hi, lo;
   logic        busy, done;
   logic [63:0] a_sx, b_sx, prod_s, prod_u, acc;

   assign a_sx   = {{32{bus.OperandA[31]}}, bus.OperandA};
   assign b_sx   = {{32{bus.OperandB[31]}}, bus.OperandB};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, bus.OperandA} * {32'd0, bus.OperandB};
   assign acc    = {hi, lo};

`ifdef MDU_DIV_EN
   logic        signed_op, div_start, div_done, neg_q, neg_r;
   logic [31:0] a_mag, b_mag, quo, rem;

   assign signed_op = (bus.Op == OP_DIV);
   assign a_mag     = (signed_op && bus.OperandA[31]) ? -bus.OperandA : bus.OperandA;
   assign b_mag     = (signed_op && bus.OperandB[31]) ? -bus.OperandB : bus.OperandB;
   assign div_start = (state == S_IDLE) && bus.Start && (bus.OperandB != '0) &&
                      ((bus.Op == OP_DIV) || (bus.Op == OP_DIVU));

   mdu_divider #(.DIV_STEPS(DIV_STEPS)) u_div (
      .clk       (Clk),
      .rst       (Rst),
      .start     (div_start),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_IDLE;
         hi    <= '0;
         lo    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef MDU_DIV_EN
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (bus.Start) begin
               done <= 1'b1;
               case (bus.Op)
                  OP_MULT:  {hi, lo} <= prod_s;
                  OP_MULTU: {hi, lo} <= prod_u;
                  OP_MADD:  {hi, lo} <= acc + prod_s;
                  OP_MSUB:  {hi, lo} <= acc - prod_s;
                  OP_MTHI:  hi <= bus.OperandA;
                  OP_MTLO:  lo <= bus.OperandA;
                  default: begin
                     // Divide by zero (or no divider built) leaves HI/LO alone and just acks.
`ifdef MDU_DIV_EN
                     if (bus.OperandB != '0) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_DIV;
                        neg_q <= signed_op && (bus.OperandA[31] ^ bus.OperandB[31]);
                        neg_r <= signed_op && bus.OperandA[31];
                     end
`endif
                  end
               endcase
            end
`ifdef MDU_DIV_EN
            S_DIV: if (div_done) state <= S_FIXUP;
            S_FIXUP: begin
               lo    <= neg_q ? -quo : quo;
               hi    <= neg_r ? -rem : rem;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.Busy   = busy;
   assign bus.Done   = done;
   assign bus.HiData = hi;
   assign bus.LoData = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit; expectations follow MDU_DIV_EN when it is defined.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic Clk = 1'b0;
   logic Rst;
   mdu_if bus();

   mult_div_unit dut (.Clk(Clk), .Rst(Rst), .bus(bus));

   always #5 Clk = ~Clk;

`ifdef MDU_DIV_EN
   localparam int DIV_BUSY    = 33;
   localparam int DIV_DONE_AT = 34;
   localparam int DIV_LAT     = 33;
`else
   localparam int DIV_BUSY    = 0;
   localparam int DIV_DONE_AT = 1;
   localparam int DIV_LAT     = 0;
`endif

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      longint x, y;
      x = $signed(a);
      y = $signed(b);
      return x * y;
   endfunction

   function automatic void mdl_div(input op_t op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      int sa, sb;
      if (op == OP_DIVU) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = '0;
      end else begin
         sa = a;
         sb = b;
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   // Reference model: results computed directly, divides delayed by a countdown.
   logic [31:0] m_hi, m_lo, pend_hi, pend_lo;
   logic        m_busy, m_done;
   int          div_left;

   always @(posedge Clk) begin : model
      logic [31:0] q, r;
      m_done <= 1'b0;
      if (Rst) begin
         m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; div_left <= 0;
      end else if (div_left > 0) begin
         if (div_left == 1) begin
            m_hi <= pend_hi; m_lo <= pend_lo; m_busy <= 1'b0; m_done <= 1'b1;
         end
         div_left <= div_left - 1;
      end else if (bus.Start) begin
         m_done <= 1'b1;
         case (bus.Op)
            OP_MULT:  {m_hi, m_lo} <= smul(bus.OperandA, bus.OperandB);
            OP_MULTU: {m_hi, m_lo} <= {32'd0, bus.OperandA} * {32'd0, bus.OperandB};
            OP_MADD:  {m_hi, m_lo} <= {m_hi, m_lo} + smul(bus.OperandA, bus.OperandB);
            OP_MSUB:  {m_hi, m_lo} <= {m_hi, m_lo} - smul(bus.OperandA, bus.OperandB);
            OP_MTHI:  m_hi <= bus.OperandA;
            OP_MTLO:  m_lo <= bus.OperandA;
            default:
               if (bus.OperandB != 0 && DIV_LAT > 0) begin
                  mdl_div(bus.Op, bus.OperandA, bus.OperandB, q, r);
                  pend_lo  <= q;
                  pend_hi  <= r;
                  m_done   <= 1'b0;
                  m_busy   <= 1'b1;
                  div_left <= DIV_LAT;
               end
         endcase
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("busy", {31'd0, bus.Busy}, {31'd0, m_busy});
         chk("done", {31'd0, bus.Done}, {31'd0, m_done});
         chk("hi", bus.HiData, m_hi);
         chk("lo", bus.LoData, m_lo);
      end
   end

   task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b);
      bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
      @(negedge Clk);
      bus.Start = 1'b0;
   endtask

   // Issues one op and watches 40 cycles; optional MULT injection / reset pulse at given cycle.
   task automatic run_div(input op_t op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input int rst_at,
                          output int nbusy, output int ndone, output int done_at);
      bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
      nbusy = 0; ndone = 0; done_at = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         bus.Start = 1'b0;
         Rst = 1'b0;
         if (bus.Busy) nbusy++;
         if (bus.Done) begin ndone++; done_at = i + 1; end
         if (i + 1 == inject_at) begin
            bus.Start = 1'b1; bus.Op = OP_MULT; bus.OperandA = 32'd5; bus.OperandB = 32'd5;
         end
         if (i + 1 == rst_at) Rst = 1'b1;
      end
   endtask

   int nb, nd, da;

   initial begin
      bus.Start = 1'b0; bus.Op = OP_MULT; bus.OperandA = '0; bus.OperandB = '0;
      Rst = 1'b1;
      @(negedge Clk);
      chk_en = 1'b1;
      repeat (2) @(negedge Clk);
      chk("rst_hi", bus.HiData, 32'h0);
      chk("rst_lo", bus.LoData, 32'h0);
      chk("rst_busy", {31'd0, bus.Busy}, 32'h0);
      chk("rst_done", {31'd0, bus.Done}, 32'h0);
      Rst = 1'b0;
      @(negedge Clk);

      issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
      chk("mult_done", {31'd0, bus.Done}, 32'h1);
      chk("mult_hi", bus.HiData, 32'hFFFF_FFFF);
      chk("mult_lo", bus.LoData, 32'hFFFF_FFFE);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      chk("multu_hi", bus.HiData, 32'h0000_0001);
      chk("multu_lo", bus.LoData, 32'hFFFF_FFFE);

      issue(OP_MTHI, 32'd0, 32'd0);
      issue(OP_MTLO, 32'd5, 32'd0);
      issue(OP_MADD, 32'd3, 32'd4);
      chk("madd_hi", bus.HiData, 32'h0);
      chk("madd_lo", bus.LoData, 32'd17);
      issue(OP_MTLO, 32'd5, 32'd0);
      issue(OP_MSUB, 32'd3, 32'd4);
      chk("msub_hi", bus.HiData, 32'hFFFF_FFFF);
      chk("msub_lo", bus.LoData, 32'hFFFF_FFF9);

      run_div(OP_DIVU, 32'd100, 32'd7, -1, -1, nb, nd, da);
      chk("divu_busy_cycles", nb, DIV_BUSY);
      chk("divu_done_count", nd, 32'd1);
      chk("divu_done_at", da, DIV_DONE_AT);
`ifdef MDU_DIV_EN
      chk("divu_lo", bus.LoData, 32'd14);
      chk("divu_hi", bus.HiData, 32'd2);
      run_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, -1, nb, nd, da);
      chk("div_neg_lo", bus.LoData, 32'hFFFF_FFFD);
      chk("div_neg_hi", bus.HiData, 32'd1);
      run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, nb, nd, da);
      chk("div_ovf_lo", bus.LoData, 32'h8000_0000);
      chk("div_ovf_hi", bus.HiData, 32'h0);
      run_div(OP_DIVU, 32'd1000, 32'd3, 10, -1, nb, nd, da);
      chk("ignored_start_done", nd, 32'd1);
      chk("ignored_start_lo", bus.LoData, 32'd333);
      chk("ignored_start_hi", bus.HiData, 32'd1);
`else
      chk("divu_off_hi", bus.HiData, 32'hFFFF_FFFF);
      chk("divu_off_lo", bus.LoData, 32'hFFFF_FFF9);
`endif

      issue(OP_MTHI, 32'h1234, 32'd0);
      issue(OP_MTLO, 32'h5678, 32'd0);
      run_div(OP_DIV, 32'd9, 32'd0, -1, -1, nb, nd, da);
      chk("div0_busy_cycles", nb, 32'd0);
      chk("div0_done_at", da, 32'd1);
      chk("div0_hi", bus.HiData, 32'h1234);
      chk("div0_lo", bus.LoData, 32'h5678);

      run_div(OP_DIV, 32'd77, 32'd5, -1, 20, nb, nd, da);
      chk("rst_mid_done", nd, (DIV_LAT > 0) ? 32'd0 : 32'd1);
      chk("rst_mid_busy", {31'd0, bus.Busy}, 32'h0);
      chk("rst_mid_hi", bus.HiData, 32'h0);
      chk("rst_mid_lo", bus.LoData, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         bus.Start    = ($urandom_range(0, 2) != 0);
         bus.Op       = op_t'($urandom_range(0, 7));
         bus.OperandA = $urandom();
         bus.OperandB = $urandom();
         case ($urandom_range(0, 7))
            0: bus.OperandB = '0;
            1: bus.OperandB = $urandom_range(1, 20);
            2: begin bus.OperandA = 32'h8000_0000; bus.OperandB = 32'hFFFF_FFFF; end
            3: bus.OperandB = -$urandom_range(1, 20);
            default: ;
         endcase
         Rst = ($urandom_range(0, 599) == 0);
         @(negedge Clk);
      end
      Rst = 1'b0;
      bus.Start = 1'b0;
      repeat (40) @(negedge Clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
